// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: FIFO-buffered byte sequencer that drives an 8-bit parallel LCD bus with timed EN pulses.
// Optional macro LCD_WRITER_LONG_WAIT_EN: clear/home commands get the long execution wait.
module lcd_bus_writer #(
  parameter int DEPTH        = 8,
  parameter int T_SETUP      = 4,
  parameter int T_EN_HIGH    = 25,
  parameter int T_HOLD       = 4,
  parameter int T_WAIT_SHORT = 2500,
  parameter int T_WAIT_LONG  = 82000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_rs,
  input  logic [7:0]             in_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   LCD_EN,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic [7:0]             LCD_DADOS,
  output logic [2:0]             dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX_A = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
  localparam int MAX_B = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
  localparam int MAX_C = (MAX_B > T_WAIT_SHORT) ? MAX_B : T_WAIT_SHORT;
`ifdef LCD_WRITER_LONG_WAIT_EN
  localparam int MAX_D = (MAX_C > T_WAIT_LONG) ? MAX_C : T_WAIT_LONG;
`else
  localparam int MAX_D = MAX_C;
`endif
  localparam int CW = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CW-1:0] C_SETUP      = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EN_HIGH    = CW'(T_EN_HIGH - 1);
  localparam logic [CW-1:0] C_HOLD       = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_WAIT_SHORT = CW'(T_WAIT_SHORT - 1);
  localparam logic [AW:0]   FULL         = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_bus_writer: DEPTH must be a power of 2 and at least 2");
  end
  if (T_SETUP < 1 || T_EN_HIGH < 1 || T_HOLD < 1 || T_WAIT_SHORT < 1 || T_WAIT_LONG < 1) begin : g_bad_timing
    $error("lcd_bus_writer: every duration must be at least one clock");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, wait_len;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  // Handshake: a byte transfers on every rising edge where in_valid && in_ready;
  // in_ready depends only on the registered count, never on this cycle's pop.
  assign in_ready  = (fifo_count < FULL);
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (fifo_count != '0) || (state != S_IDLE);
  assign LCD_RW    = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {in_rs, in_data};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

`ifdef LCD_WRITER_LONG_WAIT_EN
  localparam logic [CW-1:0] C_WAIT_LONG = CW'(T_WAIT_LONG - 1);
  logic long_sel;

  // Clear (0x01) and return-home (0x02/0x03) commands need the long execution time.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)    long_sel <= 1'b0;
    else if (pop) long_sel <= ~head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);
  end
  assign wait_len = long_sel ? C_WAIT_LONG : C_WAIT_SHORT;
`else
  assign wait_len = C_WAIT_SHORT;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = S_SETUP;
          cnt_next   = C_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_next = S_PULSE;
          cnt_next   = C_EN_HIGH;
        end else cnt_next = cnt - CW'(1);
      end
      S_PULSE: begin
        if (cnt == '0) begin
          state_next = S_HOLD;
          cnt_next   = C_HOLD;
        end else cnt_next = cnt - CW'(1);
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_next = S_WAIT;
          cnt_next   = wait_len;
        end else cnt_next = cnt - CW'(1);
      end
      S_WAIT: begin
        if (cnt == '0) state_next = S_IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  // EN is registered from the next state so it is high exactly while the FSM sits in PULSE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DADOS <= 8'h00;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      LCD_EN <= (state_next == S_PULSE);
      if (pop) {LCD_RS, LCD_DADOS} <= head;
    end
  end

endmodule
